// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, drives the instruction-memory
// read port and captures the returned word into the IF/ID pipeline register.
// Branch redirects from EXE take priority over hazard freezes so a flush is never lost.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [31:0]      branch_addr,
    output logic [31:0]      mem_address,
    output logic             mem_read,
    input  logic [31:0]      mem_read_data,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_instruction,
    output logic             if_valid,
    output logic [CNT_W-1:0] fetch_count
);

    // Reset PC is forced word-aligned so mem_address can never be misaligned.
    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      if_pc_q, if_pc_d;
    logic [31:0]      if_instr_q, if_instr_d;
    logic             if_valid_q, if_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      pc_plus4;
    logic             cnt_sat;

    // Sequential PC increment wraps mod 2^32; the counter stops at all-ones.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        cnt_sat  = &cnt_q;
    end

    // Next-state: redirect beats freeze, freeze beats normal fetch.
    always_comb begin
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        cnt_d      = cnt_q;
        if (branch_taken) begin
            // Word fetched this cycle is discarded; IF/ID becomes a bubble.
            pc_d       = {branch_addr[31:2], 2'b00};
            if_pc_d    = 32'd0;
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end else if (!freeze) begin
            pc_d       = pc_plus4;
            if_pc_d    = pc_plus4;
            if_instr_d = mem_read_data;
            if_valid_d = 1'b1;
            if (!cnt_sat) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= ResetPcAligned;
            if_pc_q    <= 32'd0;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    // Memory side is combinational from the PC; zero-latency read.
    always_comb begin
        mem_address    = pc_q;
        mem_read       = ~rst;
        if_pc          = if_pc_q;
        if_instruction = if_instr_q;
        if_valid       = if_valid_q;
        fetch_count    = cnt_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational memory model.
module tb_fetch_stage;

    localparam logic [31:0] Nop = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_read_data;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;
    logic [15:0] fetch_count;

    // Small-counter instance used to reach saturation quickly.
    logic        rst_s;
    logic [31:0] mem_address_s;
    logic        mem_read_s;
    logic [31:0] mem_read_data_s;
    logic [31:0] if_pc_s;
    logic [31:0] if_instruction_s;
    logic        if_valid_s;
    logic [3:0]  fetch_count_s;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Memory contents: word @4 is E3A00014, everything else is A000_0000 | address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd4) return 32'hE3A0_0014;
        return 32'hA000_0000 | a;
    endfunction

    always_comb mem_read_data   = mem_word(mem_address);
    always_comb mem_read_data_s = mem_word(mem_address_s);

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_valid       (if_valid),
        .fetch_count    (fetch_count)
    );

    fetch_stage #(.CNT_W(4)) dut_sat (
        .clk            (clk),
        .rst            (rst_s),
        .freeze         (1'b0),
        .branch_taken   (1'b0),
        .branch_addr    (32'd0),
        .mem_address    (mem_address_s),
        .mem_read       (mem_read_s),
        .mem_read_data  (mem_read_data_s),
        .if_pc          (if_pc_s),
        .if_instruction (if_instruction_s),
        .if_valid       (if_valid_s),
        .fetch_count    (fetch_count_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [31:0] addr, input logic [31:0] ipc,
                            input logic [31:0] instr, input logic vld, input logic [15:0] cnt);
        check_eq({tag, ".mem_address"}, mem_address, addr);
        check_eq({tag, ".if_pc"}, if_pc, ipc);
        check_eq({tag, ".if_instruction"}, if_instruction, instr);
        check_eq({tag, ".if_valid"}, 32'(if_valid), 32'(vld));
        check_eq({tag, ".fetch_count"}, 32'(fetch_count), 32'(cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rst_s = 1'b1;
        freeze = 1'b0;
        branch_taken = 1'b0;
        branch_addr = 32'd0;
        step();
        step();
        // Reset state
        check_if("reset", 32'h0, 32'h0, Nop, 1'b0, 16'd0);
        check_eq("reset.mem_read", 32'(mem_read), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("run.mem_read", 32'(mem_read), 32'd1);

        // Free-running fetch
        step();
        check_if("free1", 32'h4, 32'h4, 32'hA000_0000, 1'b1, 16'd1);
        step();
        check_if("free2", 32'h8, 32'h8, 32'hE3A0_0014, 1'b1, 16'd2);
        step();
        check_if("free3", 32'hC, 32'hC, 32'hA000_0008, 1'b1, 16'd3);

        // Freeze at pc=12 for two edges
        freeze = 1'b1;
        step();
        check_if("freeze1", 32'hC, 32'hC, 32'hA000_0008, 1'b1, 16'd3);
        step();
        check_if("freeze2", 32'hC, 32'hC, 32'hA000_0008, 1'b1, 16'd3);
        freeze = 1'b0;
        step();
        check_if("unfreeze", 32'h10, 32'h10, 32'hA000_000C, 1'b1, 16'd4);
        step();
        check_if("free4", 32'h14, 32'h14, 32'hA000_0010, 1'b1, 16'd5);

        // Misaligned branch target is forced to a word boundary
        branch_taken = 1'b1;
        branch_addr = 32'h0000_0083;
        step();
        branch_taken = 1'b0;
        check_if("branch", 32'h80, 32'h0, Nop, 1'b0, 16'd5);
        step();
        check_if("target", 32'h84, 32'h84, 32'hA000_0080, 1'b1, 16'd6);

        // Branch wins over simultaneous freeze
        branch_taken = 1'b1;
        freeze = 1'b1;
        branch_addr = 32'h0000_0040;
        step();
        branch_taken = 1'b0;
        freeze = 1'b0;
        check_if("brfreeze", 32'h40, 32'h0, Nop, 1'b0, 16'd6);
        step();
        check_if("brfreeze_next", 32'h44, 32'h44, 32'hA000_0040, 1'b1, 16'd7);

        // PC wrap at the top of the address space
        branch_taken = 1'b1;
        branch_addr = 32'hFFFF_FFFF;
        step();
        branch_taken = 1'b0;
        check_if("wrap_br", 32'hFFFF_FFFC, 32'h0, Nop, 1'b0, 16'd7);
        step();
        check_if("wrap", 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 16'd8);
        step();
        check_if("wrap_next", 32'h4, 32'h4, 32'hA000_0000, 1'b1, 16'd9);

        // Async reset between edges, with a redirect pending
        branch_taken = 1'b1;
        branch_addr = 32'h0000_0200;
        #2;
        rst = 1'b1;
        #1;
        check_if("async_rst", 32'h0, 32'h0, Nop, 1'b0, 16'd0);
        check_eq("async_rst.mem_read", 32'(mem_read), 32'd0);
        step();
        branch_taken = 1'b0;
        check_if("rst_hold", 32'h0, 32'h0, Nop, 1'b0, 16'd0);
        rst = 1'b0;
        step();
        check_if("post_rst", 32'h4, 32'h4, 32'hA000_0000, 1'b1, 16'd1);

        // Counter saturation on the 4-bit instance
        rst_s = 1'b0;
        for (int i = 0; i < 14; i++) step();
        check_eq("sat.count14", 32'(fetch_count_s), 32'd14);
        step();
        check_eq("sat.count15", 32'(fetch_count_s), 32'd15);
        for (int i = 0; i < 3; i++) step();
        check_eq("sat.hold", 32'(fetch_count_s), 32'd15);
        check_eq("sat.pc", mem_address_s, 32'd72);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
